// File: rtl/pipe_ctrl_hazard_if.sv
// pipe_ctrl_hazard_if
//   Bundles the decoder-side inputs and pipeline-control outputs of
//   pipe_ctrl_hazard. clk and rst_n stay plain ports on the module.
//   master : decoder/datapath side (drives decoder bundles, ID regs, zero flag)
//   slave  : the hazard/control block
//   Signals:
//     ex_in/m_in/wb_in      decoder EX/M/WB control bundles
//     id_rs/id_rt/id_rd     register specifiers of the instruction in ID
//     alu_zero_mem          ALU zero flag held in EX/MEM
//     ex_ctrl/mem_ctrl/wb_ctrl/wb_dst  pipeline control register contents
//     pc_write/ifid_write/ifid_flush/pc_src  front-end steering
//     fwd_a/fwd_b           ALU operand forwarding selects
//     stall_cnt/flush_cnt   saturating debug event counters
interface pipe_ctrl_hazard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [2:0]       ex_in;
    logic [2:0]       m_in;
    logic [1:0]       wb_in;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             alu_zero_mem;

    logic [2:0]       ex_ctrl;
    logic [2:0]       mem_ctrl;
    logic [1:0]       wb_ctrl;
    logic [REG_W-1:0] wb_dst;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             pc_src;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ex_in, m_in, wb_in, id_rs, id_rt, id_rd, alu_zero_mem,
        input  ex_ctrl, mem_ctrl, wb_ctrl, wb_dst, pc_write, ifid_write,
               ifid_flush, pc_src, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  ex_in, m_in, wb_in, id_rs, id_rt, id_rd, alu_zero_mem,
        output ex_ctrl, mem_ctrl, wb_ctrl, wb_dst, pc_write, ifid_write,
               ifid_flush, pc_src, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard
//   Carries decoder control bundles through the ID/EX, EX/MEM and MEM/WB
//   control registers, inserts a bubble on a load-use hazard, squashes on a
//   taken branch, drives EX-stage forwarding selects and keeps saturating
//   stall/flush event counters.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    pipe_ctrl_hazard_if.slave (see interface header for signals)
module pipe_ctrl_hazard #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_ctrl_hazard_if.slave bus
);

    // ID/EX
    logic [2:0]       idex_ex_q, idex_ex_d;
    logic [2:0]       idex_m_q, idex_m_d;
    logic [1:0]       idex_wb_q, idex_wb_d;
    logic [REG_W-1:0] idex_rs_q, idex_rt_q, idex_rd_q;
    // EX/MEM
    logic [2:0]       exmem_m_q, exmem_m_d;
    logic [1:0]       exmem_wb_q, exmem_wb_d;
    logic [REG_W-1:0] exmem_dst_q;
    // MEM/WB
    logic [1:0]       memwb_wb_q;
    logic [REG_W-1:0] memwb_dst_q;
    // counters
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic flush;
    logic stall;

    always_comb begin
        flush = exmem_m_q[2] & bus.alu_zero_mem;
        stall = idex_m_q[1] & (idex_rt_q != '0) &
                ((idex_rt_q == bus.id_rs) | (idex_rt_q == bus.id_rt));

        idex_ex_d  = bus.ex_in;
        idex_m_d   = bus.m_in;
        idex_wb_d  = bus.wb_in;
        exmem_m_d  = idex_m_q;
        exmem_wb_d = idex_wb_q;

        // Bubble into ID/EX on either event; a flush additionally kills the
        // instruction currently in EX so it never reaches MEM.
        if (flush || stall) begin
            idex_ex_d = '0;
            idex_m_d  = '0;
            idex_wb_d = '0;
        end
        if (flush) begin
            exmem_m_d  = '0;
            exmem_wb_d = '0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && !flush && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;

        flush_cnt_d = flush_cnt_q;
        if (flush && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // Register-specifier fields, EX/MEM destination and the whole MEM/WB
    // stage advance unconditionally; only the control bundles differ
    // between the flush, stall and normal cases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ex_q   <= '0;
            idex_m_q    <= '0;
            idex_wb_q   <= '0;
            idex_rs_q   <= '0;
            idex_rt_q   <= '0;
            idex_rd_q   <= '0;
            exmem_m_q   <= '0;
            exmem_wb_q  <= '0;
            exmem_dst_q <= '0;
            memwb_wb_q  <= '0;
            memwb_dst_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_ex_q   <= idex_ex_d;
            idex_m_q    <= idex_m_d;
            idex_wb_q   <= idex_wb_d;
            idex_rs_q   <= bus.id_rs;
            idex_rt_q   <= bus.id_rt;
            idex_rd_q   <= bus.id_rd;
            exmem_m_q   <= exmem_m_d;
            exmem_wb_q  <= exmem_wb_d;
            exmem_dst_q <= idex_ex_q[2] ? idex_rd_q : idex_rt_q;
            memwb_wb_q  <= exmem_wb_q;
            memwb_dst_q <= exmem_dst_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Forwarding: EX/MEM result is newer, so it wins over MEM/WB.
    always_comb begin
        bus.fwd_a = 2'b00;
        if (exmem_wb_q[1] && exmem_dst_q != '0 && exmem_dst_q == idex_rs_q)
            bus.fwd_a = 2'b10;
        else if (memwb_wb_q[1] && memwb_dst_q != '0 && memwb_dst_q == idex_rs_q)
            bus.fwd_a = 2'b01;

        bus.fwd_b = 2'b00;
        if (exmem_wb_q[1] && exmem_dst_q != '0 && exmem_dst_q == idex_rt_q)
            bus.fwd_b = 2'b10;
        else if (memwb_wb_q[1] && memwb_dst_q != '0 && memwb_dst_q == idex_rt_q)
            bus.fwd_b = 2'b01;
    end

    assign bus.ex_ctrl    = idex_ex_q;
    assign bus.mem_ctrl   = exmem_m_q;
    assign bus.wb_ctrl    = memwb_wb_q;
    assign bus.wb_dst     = memwb_dst_q;
    assign bus.pc_src     = flush;
    assign bus.ifid_flush = flush;
    assign bus.pc_write   = ~stall | flush;
    assign bus.ifid_write = ~stall | flush;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: doc/pipe_ctrl_hazard.md
Name: pipe_ctrl_hazard

Overview:
- Sequences the EX/M/WB control bundles produced by the opcode decoder through the ID/EX, EX/MEM and MEM/WB pipeline control registers.
- Detects load-use hazards and inserts bubbles; flushes on a taken branch; drives forwarding selects for the EX-stage ALU operand muxes.
- Keeps saturating stall and flush event counters for debug.
- Sits between the decoder and the datapath pipeline registers.

Parameters:
REG_W, 5, register-specifier width
CNT_W, 16, width of each event counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ex_in  in  3  decoder EX bundle {RegDst, ALUOp, ALUSrc}
m_in  in  3  decoder M bundle {Branch, MemRead, MemWrite}
wb_in  in  2  decoder WB bundle {RegWrite, MemtoReg}
id_rs  in  REG_W  rs of instruction in ID
id_rt  in  REG_W  rt of instruction in ID
id_rd  in  REG_W  rd of instruction in ID
alu_zero_mem  in  1  ALU zero flag registered into EX/MEM
ex_ctrl  out  3  ID/EX EX bundle
mem_ctrl  out  3  EX/MEM M bundle
wb_ctrl  out  2  MEM/WB WB bundle
wb_dst  out  REG_W  MEM/WB destination register
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  zero IF/ID instruction
pc_src  out  1  select branch target
fwd_a  out  2  ALU operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  out  2  ALU operand B select, same encoding
stall_cnt  out  CNT_W  stall cycles, saturating
flush_cnt  out  CNT_W  flush events, saturating

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset clears every internal register and both counters.
- After reset: ex_ctrl=0, mem_ctrl=0, wb_ctrl=0, wb_dst=0, fwd_a=fwd_b=00, pc_src=0, ifid_flush=0, pc_write=1, ifid_write=1.
- Internal registers:
  - ID/EX: idex_ex, idex_m, idex_wb, idex_rs, idex_rt, idex_rd.
  - EX/MEM: exmem_m, exmem_wb, exmem_dst.
  - MEM/WB: memwb_wb, memwb_dst.
- Outputs ex_ctrl=idex_ex, mem_ctrl=exmem_m, wb_ctrl=memwb_wb, wb_dst=memwb_dst.
- Combinational flush = exmem_m[2] & alu_zero_mem.
  - pc_src = flush; ifid_flush = flush.
- Combinational stall = idex_m[1] & (idex_rt != 0) & (idex_rt==id_rs | idex_rt==id_rt).
- pc_write = ifid_write = ~stall | flush. Flush has priority over stall.
- Register update each rising edge, in priority order:
  - flush: idex ctrl ← 0, exmem ctrl ← 0, memwb ← exmem, idex reg fields load id_*.
  - stall (no flush): idex ctrl ← 0 (bubble), exmem ← idex, memwb ← exmem, idex reg fields load id_*.
  - normal: idex ← {ex_in, m_in, wb_in, id_rs, id_rt, id_rd}, exmem ← idex, memwb ← exmem.
  - "ctrl" means the ex/m/wb bundles only.
- exmem_dst ← idex_ex[2] ? idex_rd : idex_rt.
- Forward A:
  - 10 if exmem_wb[1] & exmem_dst!=0 & exmem_dst==idex_rs;
  - else 01 if memwb_wb[1] & memwb_dst!=0 & memwb_dst==idex_rs;
  - else 00.
  - EX/MEM wins when both stages match.
- Forward B: same rules using idex_rt. Both selects are purely combinational from registered state.
- Stall and flush are combinational from registered state plus ID/MEM-stage inputs: no added latency. A control bundle appears on ex_ctrl one cycle after it is presented, on mem_ctrl after two, on wb_ctrl after three.
- Counters:
  - stall_cnt += 1 on each edge with stall & ~flush; holds at 2^CNT_W-1.
  - flush_cnt += 1 on each edge with flush; saturates the same way.
- Reset asserted mid-stream clears all state immediately (asynchronous), including counters; in-flight bundles are lost.
- Register 0 never triggers a stall or a forward.

Test Plan:
- R-type stream: ex_in=3'b110, m_in=0, wb_in=2'b10 for 3 cycles → ex_ctrl=110 at cycle 1, wb_ctrl=10 at cycle 3; pc_write=1 throughout.
- Load-use: lw with m_in=3'b010, id_rt=5 in ID, then next ID id_rs=5 → stall=1 for exactly one cycle, pc_write=0, ifid_write=0, ex_ctrl=000 next cycle; stall_cnt=1.
- Forwarding: add writes $3 (RegDst=1, id_rd=3), next instr id_rs=3, id_rt=3 → fwd_a=fwd_b=10. With one unrelated instruction between → 01/01. Write to $0 → 00/00.
- Branch taken: beq (m_in=3'b100) reaches EX/MEM with alu_zero_mem=1 → pc_src=1, ifid_flush=1, next cycle ex_ctrl=000 and mem_ctrl=000; flush_cnt=1. With alu_zero_mem=0 → no flush.
- Stall and flush same cycle: load-use in ID/EX while taken branch in EX/MEM → pc_write=1, ifid_flush=1; stall_cnt unchanged, flush_cnt+1.
- Reset mid-operation: drop rst_n asynchronously between edges → all outputs to reset values immediately; counters=0. Saturation: CNT_W=2, force 5 stalls → stall_cnt=3.
